xcorr_peak_detect: RTL and testbench
====================================

Name: xcorr_peak_detect

Overview:
- Downstream stage of the cross-correlation engine. Consumes its stream of OUTPUT_LEN correlation words (one per lag, valid-qualified pulses).
- Tracks the maximum and its lag index, then reports {peak value, peak lag, sample count} to the host/control logic through a valid/ready handshake.
- Used to estimate the inter-channel delay for the BCI front end.

Parameters:
- DATA_WIDTH, 16, sample width of the correlator inputs; correlation words are 2*DATA_WIDTH bits.
- OUTPUT_LEN, 4, number of correlation words (lags) per frame; must be >= 1.
- LAG_WIDTH, 14, width of the lag index; must satisfy 2^LAG_WIDTH >= OUTPUT_LEN.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- corr_valid  input  1  one-cycle qualifier for corr_in (no backpressure upstream).
- corr_in  input  2*DATA_WIDTH  signed correlation word.
- clear  input  1  synchronous frame abort; returns to IDLE, clears trackers.
- peak_valid  output  1  result available.
- peak_ready  input  1  consumer accepts result.
- peak_value  output  2*DATA_WIDTH  signed correlation value at the peak.
- peak_lag  output  LAG_WIDTH  lag index (0-based, arrival order) of the peak.
- overrun  output  1  sticky: a corr_valid arrived while a result was pending.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, peak_valid=0, peak_value=0, peak_lag=0, overrun=0, lag counter=0, tracker cleared.
- States: IDLE, ACCUM, REPORT.
- IDLE:
  - corr_valid=1 → the word is lag 0; load the tracker with it; counter=1.
  - If OUTPUT_LEN==1, go directly to REPORT; else go to ACCUM.
- ACCUM:
  - Each corr_valid compares the word against the tracker. A word strictly greater replaces the tracker, and peak_lag takes the current counter. Ties keep the earlier lag.
  - Counter increments on every accepted word.
  - When the word with counter==OUTPUT_LEN-1 is accepted, go to REPORT next cycle.
  - Gaps with corr_valid=0 are allowed indefinitely.
- REPORT:
  - peak_valid=1 with peak_value and peak_lag stable.
  - Handshake completes on the cycle where peak_valid && peak_ready. Then peak_valid=0 next cycle, state=IDLE, counter=0.
  - Latency: peak_valid asserts exactly 1 cycle after the last word's corr_valid.
- Compare rule: signed comparison on 2*DATA_WIDTH bits (see optional feature).
- corr_valid in REPORT: word dropped, overrun set to 1.
  - overrun clears only on reset_n or on clear.
  - The next frame starts only after the handshake.
- Handshake cycle with simultaneous corr_valid: the word counts as overrun (the frame is not yet IDLE).
- clear=1 in any state: next cycle state=IDLE, peak_valid=0, counter=0, overrun=0. Any corr_valid in the same cycle is ignored. clear has priority over everything except reset_n.
- reset_n asserted mid-frame or mid-REPORT: all outputs return to reset values immediately; partial frame is discarded.
- Counter never wraps within a frame; terminal count is OUTPUT_LEN-1.

Optional Feature:
- Macro: XCORR_PEAK_ABS_EN.
- Defined:
  - Comparison uses the magnitude |corr_in|, computed as an unsigned 2*DATA_WIDTH-bit value. The most-negative input maps to 2^(2*DATA_WIDTH-1) with no overflow.
  - peak_value still reports the original signed word.
  - Anti-correlated peaks are detected.
- Not defined: plain signed maximum; the most-negative word is the smallest.

Test Plan:
- OUTPUT_LEN=4, words 10, 50, -3, 20, peak_ready=1 → peak_valid one cycle after the 4th word, peak_value=50, peak_lag=1, then IDLE.
- Words 7, 7, 7, 7 → peak_value=7, peak_lag=0 (tie keeps the earliest).
- Words 5, -100, 30, 2:
  - Without XCORR_PEAK_ABS_EN → peak_value=30, lag=2.
  - With it → peak_value=-100, lag=1.
  - Also feed the most-negative word with ABS enabled → selected, lag correct.
- Complete a frame, hold peak_ready=0 for 5 cycles and pulse corr_valid twice → result held stable, overrun=1. Raise peak_ready → peak_valid drops. Next frame processes normally with overrun still 1 until clear.
- Two words in, then clear=1 → IDLE, overrun=0. A new frame 1, 2, 3, 4 → peak_value=4, lag=3 (no residue from the aborted frame).
- reset_n pulsed low asynchronously mid-ACCUM and during REPORT → all outputs 0 immediately. Following frame 9, 8, 1, 0 → peak_value=9, lag=0.

Source files
------------

// File: rtl/xcorr_peak_detect.sv
// Peak tracker for the cross-correlation stream: finds the maximum word of each
// OUTPUT_LEN-lag frame and hands {value, lag} to the host via valid/ready.
// Define XCORR_PEAK_ABS_EN to rank words by magnitude instead of signed value.
module xcorr_peak_detect #(
  parameter int DATA_WIDTH = 16,
  parameter int OUTPUT_LEN = 4,
  parameter int LAG_WIDTH  = 14
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    corr_valid,
  input  logic [2*DATA_WIDTH-1:0] corr_in,
  input  logic                    clear,
  output logic                    peak_valid,
  input  logic                    peak_ready,
  output logic [2*DATA_WIDTH-1:0] peak_value,
  output logic [LAG_WIDTH-1:0]    peak_lag,
  output logic                    overrun
);

  localparam int CW = 2*DATA_WIDTH;
  localparam logic [LAG_WIDTH-1:0] LAST_LAG = LAG_WIDTH'(OUTPUT_LEN-1);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t               state;
  logic [LAG_WIDTH-1:0] cnt;
  logic                 better;

  // Map a word to an unsigned ranking key so one unsigned compare serves both modes.
  function automatic logic [CW-1:0] rank_key(input logic [CW-1:0] w);
`ifdef XCORR_PEAK_ABS_EN
    // Two's-complement negate; the most-negative word lands on 2^(CW-1) unsigned.
    return w[CW-1] ? CW'(~w + 1'b1) : w;
`else
    // Offset-binary: flipping the sign bit makes unsigned order match signed order.
    return {~w[CW-1], w[CW-2:0]};
`endif
  endfunction

  assign better = rank_key(corr_in) > rank_key(peak_value);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      peak_valid <= 1'b0;
      peak_value <= '0;
      peak_lag   <= '0;
      overrun    <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      cnt        <= '0;
      peak_valid <= 1'b0;
      peak_value <= '0;
      peak_lag   <= '0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (corr_valid) begin
            peak_value <= corr_in;
            peak_lag   <= '0;
            cnt        <= LAG_WIDTH'(1);
            if (OUTPUT_LEN == 1) begin
              state      <= REPORT;
              peak_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (corr_valid) begin
            // Strictly greater only, so ties keep the earliest lag.
            if (better) begin
              peak_value <= corr_in;
              peak_lag   <= cnt;
            end
            if (cnt == LAST_LAG) begin
              state      <= REPORT;
              peak_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          // Result still pending, including the handshake cycle itself.
          if (corr_valid) overrun <= 1'b1;
          if (peak_ready) begin
            state      <= IDLE;
            peak_valid <= 1'b0;
            cnt        <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          peak_valid <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// Self-checking bench for xcorr_peak_detect: vector table of frames plus
// hand-written sequences for overrun, clear and asynchronous reset.
module tb_xcorr_peak_detect;
  localparam int DW = 16;
  localparam int OL = 4;
  localparam int LW = 14;
  localparam int CW = 2*DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          corr_valid = 1'b0;
  logic [CW-1:0] corr_in = '0;
  logic          clear = 1'b0;
  logic          peak_ready = 1'b0;
  logic          peak_valid;
  logic [CW-1:0] peak_value;
  logic [LW-1:0] peak_lag;
  logic          overrun;

  xcorr_peak_detect #(.DATA_WIDTH(DW), .OUTPUT_LEN(OL), .LAG_WIDTH(LW)) dut (
    .clk(clk), .reset_n(reset_n), .corr_valid(corr_valid), .corr_in(corr_in),
    .clear(clear), .peak_valid(peak_valid), .peak_ready(peak_ready),
    .peak_value(peak_value), .peak_lag(peak_lag), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef logic [OL-1:0][CW-1:0] frame_t;
  typedef struct packed {
    frame_t        w;
    logic [CW-1:0] val;
    logic [LW-1:0] lag;
  } vec_t;
  typedef struct packed {
    logic [CW-1:0] val;
    logic [LW-1:0] lag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic frame_t mk(input int a, input int b, input int c, input int d);
    frame_t f;
    f[0] = a; f[1] = b; f[2] = c; f[3] = d;
    return f;
  endfunction

  function automatic exp_t ex(input int v, input int l);
    exp_t e;
    e.val = v;
    e.lag = LW'(l);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t w, input int gap, input exp_t e);
    sb.push_back(e);
    for (int i = 0; i < OL; i++) begin
      corr_valid = 1'b1;
      corr_in    = w[i];
      tick();
      corr_valid = 1'b0;
      if (i == OL-1) check("latency", 64'(peak_valid), 64'd1);
      else begin
        check("early_valid", 64'(peak_valid), 64'd0);
        for (int g = 0; g < gap; g++) tick();
      end
    end
  endtask

  task automatic collect();
    int   t;
    exp_t e;
    t = 0;
    while (!peak_valid && t < 20) begin
      tick();
      t++;
    end
    n_cmp++;
    if (!peak_valid) begin
      n_err++;
      $display("FAIL timeout: peak_valid not seen within 20 cycles");
    end else if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_result: value %0h with empty scoreboard", peak_value);
    end else begin
      e = sb.pop_front();
      check("peak_value", 64'(peak_value), 64'(e.val));
      check("peak_lag", 64'(peak_lag), 64'(e.lag));
    end
  endtask

  task automatic accept();
    peak_ready = 1'b1;
    tick();
    peak_ready = 1'b0;
    check("valid_drop", 64'(peak_valid), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{w: mk(10, 50, -3, 20), val: 50, lag: 1};
    vecs[1] = '{w: mk(7, 7, 7, 7), val: 7, lag: 0};
    vecs[5] = '{w: mk(1, 2, 3, 4), val: 4, lag: 3};
`ifdef XCORR_PEAK_ABS_EN
    vecs[2] = '{w: mk(5, -100, 30, 2), val: -100, lag: 1};
    vecs[3] = '{w: mk(-5, -2, -9, -2), val: -9, lag: 2};
    vecs[4] = '{w: mk(32'h8000_0000, 3, -7, 5), val: 32'h8000_0000, lag: 0};
    vecs[6] = '{w: mk(0, 32'h7fff_ffff, 32'h8000_0000, 1), val: 32'h8000_0000, lag: 2};
`else
    vecs[2] = '{w: mk(5, -100, 30, 2), val: 30, lag: 2};
    vecs[3] = '{w: mk(-5, -2, -9, -2), val: -2, lag: 1};
    vecs[4] = '{w: mk(32'h8000_0000, 3, -7, 5), val: 5, lag: 3};
    vecs[6] = '{w: mk(0, 32'h7fff_ffff, 32'h8000_0000, 1), val: 32'h7fff_ffff, lag: 1};
`endif

    // Reset state
    #2;
    check("rst_valid", 64'(peak_valid), 64'd0);
    check("rst_value", 64'(peak_value), 64'd0);
    check("rst_lag", 64'(peak_lag), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    #14 reset_n = 1'b1;
    tick();

    // Table-driven frames, odd entries with idle gaps between words
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].w, i % 2, ex(int'(vecs[i].val), int'(vecs[i].lag)));
      collect();
      accept();
      tick();
    end

    // Result held with backpressure; words arriving meanwhile are overrun
    send_frame(mk(10, 50, -3, 20), 0, ex(50, 1));
    for (int c = 0; c < 5; c++) begin
      corr_valid = (c == 1 || c == 3);
      corr_in    = 32'd1000;
      tick();
    end
    corr_valid = 1'b0;
    check("hold_valid", 64'(peak_valid), 64'd1);
    check("overrun_set", 64'(overrun), 64'd1);
    collect();
    accept();
    send_frame(mk(3, 1, 2, 0), 0, ex(3, 0));
    collect();
    check("overrun_sticky", 64'(overrun), 64'd1);
    accept();

    // Abort mid-frame; the word in the clear cycle must be ignored
    corr_valid = 1'b1; corr_in = 32'd100; tick();
    corr_in = 32'd200; tick();
    clear = 1'b1; corr_in = 32'd500; tick();
    clear = 1'b0; corr_valid = 1'b0;
    check("clr_overrun", 64'(overrun), 64'd0);
    check("clr_valid", 64'(peak_valid), 64'd0);
    check("clr_value", 64'(peak_value), 64'd0);
    send_frame(mk(1, 2, 3, 4), 0, ex(4, 3));
    collect();

    // Word on the handshake cycle still counts as overrun
    corr_valid = 1'b1; corr_in = 32'd77; peak_ready = 1'b1;
    tick();
    corr_valid = 1'b0; peak_ready = 1'b0;
    check("hs_valid", 64'(peak_valid), 64'd0);
    check("hs_overrun", 64'(overrun), 64'd1);
    send_frame(mk(-1, -1, 6, 6), 0, ex(6, 2));
    collect();
    accept();

    // Asynchronous reset mid-ACCUM
    corr_valid = 1'b1; corr_in = 32'd900; tick();
    corr_in = 32'd950; tick();
    corr_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1 check("arst_accum_value", 64'(peak_value), 64'd0);
    check("arst_accum_lag", 64'(peak_lag), 64'd0);
    check("arst_accum_overrun", 64'(overrun), 64'd0);
    #1 reset_n = 1'b1;
    tick();

    // Asynchronous reset during REPORT, with overrun set
    send_frame(mk(11, 12, 13, 14), 0, ex(14, 3));
    corr_valid = 1'b1; corr_in = 32'd5; tick();
    corr_valid = 1'b0;
    check("pre_rst_overrun", 64'(overrun), 64'd1);
    collect();
    #3 reset_n = 1'b0;
    #1 check("arst_rep_valid", 64'(peak_valid), 64'd0);
    check("arst_rep_value", 64'(peak_value), 64'd0);
    check("arst_rep_lag", 64'(peak_lag), 64'd0);
    check("arst_rep_overrun", 64'(overrun), 64'd0);
    #1 reset_n = 1'b1;
    tick();
    send_frame(mk(9, 8, 1, 0), 1, ex(9, 0));
    collect();
    accept();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
